// File: rtl/regfile_read_unit_pkg.sv
// Shared types and constants for the register file read unit.
// Holds the default geometry (32 x 32-bit registers), the hard-wired zero
// register address, and the address/word typedefs reused by decode and
// write-back logic.
package regfile_read_unit_pkg;

    localparam int REG_N  = 32;
    localparam int REG_AW = 5;

    typedef logic [REG_AW-1:0] regaddr_t;
    typedef logic [REG_N-1:0]  word_t;

    localparam regaddr_t REG_ZERO_ADDR = '0;

endpackage

// File: rtl/regfile_read_unit_if.sv
// Bus interface of the register file read unit.
// Groups the write port (LE/wa/Datain), the read request channel
// (req_valid/req_ready/ra/rb) and the response channel
// (rsp_valid/rsp_ready/QA/QB).
//   master : the datapath side (drives writes, requests, rsp_ready)
//   slave  : the register file (drives req_ready, rsp_valid, QA, QB)
interface regfile_read_unit_if
    import regfile_read_unit_pkg::*;
#(
    parameter int N  = REG_N,
    parameter int AW = REG_AW
);
    logic          LE;
    logic [AW-1:0] wa;
    logic [N-1:0]  Datain;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [N-1:0]  QA;
    logic [N-1:0]  QB;

    modport master (
        output LE, wa, Datain, req_valid, ra, rb, rsp_ready,
        input  req_ready, rsp_valid, QA, QB
    );

    modport slave (
        input  LE, wa, Datain, req_valid, ra, rb, rsp_ready,
        output req_ready, rsp_valid, QA, QB
    );
endinterface

// File: rtl/regfile_read_mux.sv
// Per-port read select: produces the value returned for one read address.
// Register 0 always yields zero. When REGFILE_BYPASS_EN is defined, a write
// to the same (nonzero) address in the same cycle is forwarded (write-first);
// otherwise the stored contents are returned (read-first).
// Ports:
//   addr   : read address
//   stored : current array contents at addr
//   we/wa/wdata : write port (only present with REGFILE_BYPASS_EN)
//   value  : selected read data
module regfile_read_mux
    import regfile_read_unit_pkg::*;
#(
    parameter int N  = REG_N,
    parameter int AW = REG_AW
) (
    input  logic [AW-1:0] addr,
    input  logic [N-1:0]  stored,
`ifdef REGFILE_BYPASS_EN
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [N-1:0]  wdata,
`endif
    output logic [N-1:0]  value
);

    always_comb begin
        value = stored;
`ifdef REGFILE_BYPASS_EN
        if (we && (wa != AW'(REG_ZERO_ADDR)) && (wa == addr)) begin
            value = wdata;
        end
`endif
        // Zero register wins over everything, including forwarding.
        if (addr == AW'(REG_ZERO_ADDR)) begin
            value = '0;
        end
    end

endmodule

// File: rtl/regfile_read_unit.sv
// Register file read unit: 2^AW x N-bit registers, one write port, two read
// ports (A/B) behind a valid/ready request channel and a one-entry registered
// response stage. Register 0 reads as zero and is never written.
// Optional feature: define REGFILE_BYPASS_EN for same-cycle write forwarding.
// Ports:
//   clk : clock, all state changes on rising edge
//   Clr : synchronous active-high reset (clears registers and response stage)
//   bus : regfile_read_unit_if.slave (write port, request, response)
module regfile_read_unit
    import regfile_read_unit_pkg::*;
#(
    parameter int N  = REG_N,
    parameter int AW = REG_AW
) (
    input  logic                      clk,
    input  logic                      Clr,
    regfile_read_unit_if.slave        bus
);

    localparam int NREG = 1 << AW;

    logic [N-1:0]  regs_q [NREG];
    logic [N-1:0]  regs_d [NREG];

    logic          rsp_valid_q, rsp_valid_d;
    logic [N-1:0]  qa_q, qa_d;
    logic [N-1:0]  qb_q, qb_d;

    logic          accept;
    logic [AW-1:0] rd_addr  [2];
    logic [N-1:0]  rd_value [2];

    // Write port; entry 0 is held at zero so it never stores anything.
    always_comb begin
        regs_d[0] = '0;
        for (int i = 1; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
            if (bus.LE && (bus.wa == AW'(i))) begin
                regs_d[i] = bus.Datain;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (Clr) begin
                regs_q[i] <= '0;
            end else begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read ports A (0) and B (1) share one select implementation.
    assign rd_addr[0] = bus.ra;
    assign rd_addr[1] = bus.rb;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            regfile_read_mux #(
                .N  (N),
                .AW (AW)
            ) u_mux (
                .addr   (rd_addr[gi]),
                .stored (regs_q[rd_addr[gi]]),
`ifdef REGFILE_BYPASS_EN
                .we     (bus.LE),
                .wa     (bus.wa),
                .wdata  (bus.Datain),
`endif
                .value  (rd_value[gi])
            );
        end
    endgenerate

    // Output stage: accept whenever the slot is empty or is being drained.
    assign bus.req_ready = !rsp_valid_q || bus.rsp_ready;
    assign accept        = bus.req_valid && bus.req_ready;

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        qa_d        = qa_q;
        qb_d        = qb_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            qa_d        = rd_value[0];
            qb_d        = rd_value[1];
        end else if (bus.rsp_ready) begin
            // Consumed with nothing new; data is left as-is (don't-care).
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (Clr) begin
            rsp_valid_q <= 1'b0;
            qa_q        <= '0;
            qb_q        <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            qa_q        <= qa_d;
            qb_q        <= qb_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.QA        = qa_q;
    assign bus.QB        = qb_q;

endmodule

// File: tb/tb_regfile_read_unit.sv
// Directed testbench for regfile_read_unit: reset state, writes, zero
// register, same-cycle write/read ordering, stall snapshot, back-to-back
// throughput and mid-stream reset.
module tb_regfile_read_unit;
    import regfile_read_unit_pkg::*;

    logic clk = 1'b0;
    logic Clr;
    int   tests = 0;
    int   fails = 0;

    regfile_read_unit_if #(.N(REG_N), .AW(REG_AW)) bus ();

    regfile_read_unit #(.N(REG_N), .AW(REG_AW)) dut (
        .clk (clk),
        .Clr (Clr),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("[TB] check %s observed=%h expected=%h", tag, obs, exp);
    endtask

    logic [31:0] same_cycle_exp;

    initial begin
`ifdef REGFILE_BYPASS_EN
        same_cycle_exp = 32'h1234_5678;
`else
        same_cycle_exp = 32'h0000_0000;
`endif
        Clr = 1'b1;
        bus.LE = 1'b0; bus.wa = '0; bus.Datain = '0;
        bus.req_valid = 1'b0; bus.ra = '0; bus.rb = '0;
        bus.rsp_ready = 1'b1;
        tick(); tick();
        Clr = 1'b0;
        chk("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("reset_qa", bus.QA, 32'd0);
        chk("reset_qb", bus.QB, 32'd0);
        chk("reset_req_ready", {31'd0, bus.req_ready}, 32'd1);

        // Read after reset: ra=3, rb=0
        bus.req_valid = 1'b1; bus.ra = 5'd3; bus.rb = 5'd0;
        tick();
        bus.req_valid = 1'b0;
        chk("rd3_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("rd3_qa", bus.QA, 32'd0);
        chk("rd3_qb", bus.QB, 32'd0);

        // Write reg 5; the response drains during this cycle
        bus.LE = 1'b1; bus.wa = 5'd5; bus.Datain = 32'hDEAD_BEEF;
        tick();
        bus.LE = 1'b0;
        chk("drain_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        bus.req_valid = 1'b1; bus.ra = 5'd5; bus.rb = 5'd5;
        tick();
        bus.req_valid = 1'b0;
        chk("rd5_qa", bus.QA, 32'hDEAD_BEEF);
        chk("rd5_qb", bus.QB, 32'hDEAD_BEEF);
        chk("rd5_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);

        // Write to reg 0 is ignored
        bus.LE = 1'b1; bus.wa = 5'd0; bus.Datain = 32'hFFFF_FFFF;
        tick();
        bus.LE = 1'b0;
        bus.req_valid = 1'b1; bus.ra = 5'd0; bus.rb = 5'd5;
        tick();
        bus.req_valid = 1'b0;
        chk("rd0_qa", bus.QA, 32'd0);
        chk("rd0_qb", bus.QB, 32'hDEAD_BEEF);

        // Same-cycle write and read of reg 7
        bus.LE = 1'b1; bus.wa = 5'd7; bus.Datain = 32'h1234_5678;
        bus.req_valid = 1'b1; bus.ra = 5'd7; bus.rb = 5'd7;
        tick();
        bus.LE = 1'b0;
        chk("same_cycle_qa", bus.QA, same_cycle_exp);
        chk("same_cycle_qb", bus.QB, same_cycle_exp);
        bus.rb = 5'd0;
        tick();
        bus.req_valid = 1'b0;
        chk("rd7_again_qa", bus.QA, 32'h1234_5678);

        // Stall: snapshot of reg 2 held while reg 2 is overwritten
        bus.LE = 1'b1; bus.wa = 5'd2; bus.Datain = 32'h0000_000A;
        tick();
        bus.LE = 1'b0;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1; bus.ra = 5'd2; bus.rb = 5'd0;
        tick();
        bus.req_valid = 1'b0;
        chk("stall_qa", bus.QA, 32'h0000_000A);
        chk("stall_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("stall_req_ready", {31'd0, bus.req_ready}, 32'd0);
        bus.LE = 1'b1; bus.wa = 5'd2; bus.Datain = 32'h0000_000B;
        bus.req_valid = 1'b1; bus.ra = 5'd3;   // must not be accepted
        tick();
        bus.LE = 1'b0; bus.req_valid = 1'b0;
        chk("stall_after_write_qa", bus.QA, 32'h0000_000A);
        tick(); tick();
        chk("stall_3cyc_qa", bus.QA, 32'h0000_000A);
        chk("stall_3cyc_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        bus.rsp_ready = 1'b1;
        #1;
        chk("release_req_ready", {31'd0, bus.req_ready}, 32'd1);
        tick();
        chk("consumed_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        bus.req_valid = 1'b1; bus.ra = 5'd2; bus.rb = 5'd0;
        tick();
        bus.req_valid = 1'b0;
        chk("rd2_new_qa", bus.QA, 32'h0000_000B);

        // Load regs 1..4 with 1..4
        for (int i = 1; i <= 4; i++) begin
            bus.LE = 1'b1; bus.wa = 5'(i); bus.Datain = 32'(i);
            tick();
        end
        bus.LE = 1'b0;

        // Back-to-back reads, one response per cycle
        bus.req_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.ra = 5'(i); bus.rb = 5'(5 - i);
            tick();
            chk($sformatf("b2b_qa_%0d", i), bus.QA, 32'(i));
            chk($sformatf("b2b_qb_%0d", i), bus.QB, 32'(5 - i));
            chk($sformatf("b2b_valid_%0d", i), {31'd0, bus.rsp_valid}, 32'd1);
        end

        // Reset mid-stream takes priority over the pending accept
        Clr = 1'b1; bus.ra = 5'd4; bus.LE = 1'b1; bus.wa = 5'd9; bus.Datain = 32'h5555_5555;
        tick();
        Clr = 1'b0; bus.LE = 1'b0; bus.req_valid = 1'b0;
        chk("clr_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("clr_qa", bus.QA, 32'd0);
        chk("clr_qb", bus.QB, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            bus.req_valid = 1'b1; bus.ra = 5'(i); bus.rb = 5'(i + 5);
            tick();
            chk($sformatf("post_clr_qa_%0d", i), bus.QA, 32'd0);
            chk($sformatf("post_clr_qb_%0d", i), bus.QB, 32'd0);
        end
        bus.req_valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
